// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyser capture controller.
// Contents:
//   LA_ADDR_W  - default acquisition-RAM address width
//   la_state_t - capture FSM state encoding (visible on the state output)
package la_pkg;

    localparam int LA_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } la_state_t;

endpackage

// File: rtl/la_mod_counter.sv
// Wrapping up-counter used as the acquisition-RAM write pointer.
// Ports:
//   PCI_CLK  - clock
//   PCI_RSTn - synchronous active-low reset, forces q to 0
//   clr      - synchronous clear (wins over en)
//   en       - advance by one, wrapping modulo 2^W
//   q        - current count
module la_mod_counter #(
    parameter int W = 8
) (
    input  logic         PCI_CLK,
    input  logic         PCI_RSTn,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge PCI_CLK) begin
        if (!PCI_RSTn)  q <= '0;
        else if (clr)   q <= '0;
        else if (en)    q <= q + W'(1);
    end

endmodule

// File: rtl/la_capture_ctrl.sv
// Capture controller for a circular acquisition RAM: writes a pre-trigger
// window, waits for a trigger, writes a post-trigger window, then reports
// where the trigger and the oldest valid sample landed.
// Ports:
//   PCI_CLK, PCI_RSTn     - clock, synchronous active-low reset
//   arm, abort, clr       - host control (start / cancel / readout finished)
//   trigger               - qualified trigger, sampled every cycle
//   cfg_pre, cfg_post     - pre/post-trigger sample counts
//   ram_we, ram_waddr     - acquisition-RAM write port
//   trig_addr, start_addr - trigger sample address, oldest valid sample
//   busy, done, cfg_err   - status; state exposes the FSM encoding
module la_capture_ctrl
    import la_pkg::*;
#(
    parameter int ADDR_W = LA_ADDR_W
) (
    input  logic              PCI_CLK,
    input  logic              PCI_RSTn,
    input  logic              arm,
    input  logic              abort,
    input  logic              trigger,
    input  logic              clr,
    input  logic [ADDR_W-1:0] cfg_pre,
    input  logic [ADDR_W-1:0] cfg_post,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] start_addr,
    output logic              busy,
    output logic              done,
    output logic              cfg_err,
    output logic [2:0]        state
);

    la_state_t         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q;           // shared pre/post down-counter
    logic [ADDR_W-1:0] pre_q, post_q;   // configuration latched at arm
    logic [ADDR_W:0]   cfg_sum;
    logic              arm_seen;        // arm is considered in this state
    logic              cfg_over;
    logic              accept;
    logic              trig_hit;
    logic              acq_state;

    assign cfg_sum   = {1'b0, cfg_pre} + {1'b0, cfg_post};
    // Windows that together exceed the RAM depth minus one would overwrite
    // the pre-trigger data, so such an arm is refused.
    assign cfg_over  = cfg_sum[ADDR_W];
    assign arm_seen  = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
    assign accept    = arm_seen && !cfg_over;
    assign trig_hit  = (state_q == ST_ARMED) && trigger && !abort;
    assign acq_state = (state_q == ST_PRE) || (state_q == ST_ARMED) || (state_q == ST_POST);

    // The reset term keeps the RAM untouched in the cycle an acquisition is
    // abandoned by reset.
    assign ram_we = PCI_RSTn && acq_state && !abort;
    assign state  = state_q;

    la_mod_counter #(.W(ADDR_W)) u_waddr (
        .PCI_CLK  (PCI_CLK),
        .PCI_RSTn (PCI_RSTn),
        .clr      (accept),
        .en       (ram_we),
        .q        (ram_waddr)
    );

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = (cfg_pre == '0) ? ST_ARMED : ST_PRE;
                end
                ST_DONE: begin
                    // arm (even a refused one) takes priority over clr
                    if (arm) begin
                        if (accept) state_d = (cfg_pre == '0) ? ST_ARMED : ST_PRE;
                    end else if (clr) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PRE: begin
                    if (cnt_q == ADDR_W'(1)) state_d = ST_ARMED;
                end
                ST_ARMED: begin
                    if (trigger) state_d = (post_q == '0) ? ST_DONE : ST_POST;
                end
                ST_POST: begin
                    if (cnt_q == ADDR_W'(1)) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PCI_CLK) begin
        if (!PCI_RSTn) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pre_q      <= '0;
            post_q     <= '0;
            trig_addr  <= '0;
            start_addr <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_err <= arm_seen && cfg_over;
            busy    <= (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
            done    <= (state_d == ST_DONE);

            if (accept) begin
                pre_q  <= cfg_pre;
                post_q <= cfg_post;
                cnt_q  <= cfg_pre;
            end else if (trig_hit) begin
                cnt_q  <= post_q;
            end else if (ram_we && (state_q == ST_PRE || state_q == ST_POST)) begin
                cnt_q  <= cnt_q - ADDR_W'(1);
            end

            if (trig_hit) begin
                trig_addr  <= ram_waddr;
                start_addr <= ram_waddr - pre_q;
            end
        end
    end

endmodule
